// File: rtl/btn_scan_debouncer.sv
// Debouncer for NUM_BTNS buttons. One prescaler and one stability datapath are shared by all buttons.
// A round-robin scan visits each button once per sample tick.
module btn_scan_debouncer #(
  parameter int CLK_FREQ       = 25_000_000,
  parameter int NUM_BTNS       = 4,
  parameter int SAMPLE_HZ      = 1_000,
  parameter int STABLE_SAMPLES = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_out,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic                scan_busy
);

  localparam int TICK_DIV = CLK_FREQ / SAMPLE_HZ;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W    = $clog2(STABLE_SAMPLES + 1);
  localparam int IDX_W    = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_BTNS - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STABLE_SAMPLES - 1);

  generate
    if (TICK_DIV <= NUM_BTNS + 1) begin : g_tick_check
      $error("btn_scan_debouncer: TICK_DIV must exceed NUM_BTNS+1 so a scan ends before the next tick");
    end
    if (NUM_BTNS < 1 || STABLE_SAMPLES < 1) begin : g_size_check
      $error("btn_scan_debouncer: NUM_BTNS and STABLE_SAMPLES must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, SCAN} state_t;

  logic [NUM_BTNS-1:0] meta_p0;
  logic [NUM_BTNS-1:0] sync_p1;
  logic [PRESC_W-1:0]  presc;
  logic                tick;
  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [CNT_W-1:0]    cnt [NUM_BTNS];
  logic                cur_sync;
  logic                cur_out;
  logic [CNT_W-1:0]    cur_cnt;
  logic [CNT_W-1:0]    cnt_upd;
  logic                accept;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= btn_in;
      sync_p1 <= meta_p0;
    end
  end

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // A tick arriving while in SCAN is deliberately dropped
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        if (idx == IDX_LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign scan_busy = (state == SCAN);

  // Shared stability datapath: operand mux of the button selected by idx
  always_comb begin
    cur_sync = sync_p1[idx];
    cur_out  = btn_out[idx];
    cur_cnt  = cnt[idx];
    cnt_upd  = '0;
    accept   = 1'b0;
    if (cur_sync != cur_out) begin
      if (cur_cnt == CNT_LAST) begin
        accept = 1'b1;
      end else begin
        cnt_upd = cur_cnt + 1'b1;
      end
    end
  end

  // Stage p2: write-back of the selected button's counter and level; strobes self-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_out     <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      if (scan_busy) begin
        cnt[idx] <= cnt_upd;
        if (accept) begin
          btn_out[idx]     <= cur_sync;
          btn_press[idx]   <= cur_sync;
          btn_release[idx] <= ~cur_sync;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_scan_debouncer.sv
// Randomised bench for btn_scan_debouncer with a sample-schedule reference model and scoreboard.
module tb_btn_scan_debouncer;

  localparam int CLK_FREQ = 1000;
  localparam int SAMPLE_HZ = 100;
  localparam int TD = CLK_FREQ / SAMPLE_HZ;
  localparam int NB = 4;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_out;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          scan_busy;

  btn_scan_debouncer #(
    .CLK_FREQ      (CLK_FREQ),
    .NUM_BTNS      (NB),
    .SAMPLE_HZ     (SAMPLE_HZ),
    .STABLE_SAMPLES(SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_out    (btn_out),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .scan_busy  (scan_busy)
  );

  always #5 clk = ~clk;

  // cycle n = the clock period that follows the n-th rising edge after reset release
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int   cyc;
    int   b;
    logic press;
  } ev_t;

  ev_t           exp_q[$];
  logic [NB-1:0] mdl_lvl = '0;
  int            mdl_run[NB];
  logic [NB-1:0] cur = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Button i takes the level that was on btn_in in cycle tick-1+i; a change accepted
  // from that sample shows on the outputs 3 cycles later (2 sync + 1 register).
  task automatic model_cycle(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) begin
      int t;
      t = cyc + 1 - i;
      if (t >= TD - 1 && (t + 1) % TD == 0) begin
        if (v[i] == mdl_lvl[i]) begin
          mdl_run[i] = 0;
        end else begin
          mdl_run[i]++;
          if (mdl_run[i] == SS) begin
            mdl_lvl[i] = v[i];
            mdl_run[i] = 0;
            exp_q.push_back('{cyc: cyc + 3, b: i, press: v[i]});
          end
        end
      end
    end
  endtask

  task automatic step(input logic [NB-1:0] v);
    @(posedge clk);
    #2;
    btn_in = v;
    model_cycle(v);
  endtask

  task automatic hold_to(input int m);
    do step(cur); while (cyc % TD != m);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    mdl_lvl = '0;
    for (int i = 0; i < NB; i++) mdl_run[i] = 0;
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin : monitor
    logic [NB-1:0] exp_out;
    logic [NB-1:0] ep;
    logic [NB-1:0] er;
    ev_t           ev;
    exp_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_out = '0;
        check("rst_btn_out", 32'(btn_out), 0);
        check("rst_press", 32'(btn_press), 0);
        check("rst_release", 32'(btn_release), 0);
        check("rst_busy", 32'(scan_busy), 0);
      end else begin
        check("scan_busy", 32'(scan_busy), 32'(cyc >= TD && (cyc % TD) < NB));
        ep = '0;
        er = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          ev = exp_q.pop_front();
          if (ev.press) ep[ev.b] = 1'b1;
          else          er[ev.b] = 1'b1;
          exp_out[ev.b] = ev.press;
        end
        check("btn_press", 32'(btn_press), 32'(ep));
        check("btn_release", 32'(btn_release), 32'(er));
        check("btn_out", 32'(btn_out), 32'(exp_out));
      end
    end
  end

  initial begin : stimulus
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) mdl_run[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // idle inputs: first tick, busy window, quiet outputs
    repeat (30) step(cur);

    // single held press on bit 2
    hold_to(4);
    cur[2] = 1'b1;
    repeat (60) step(cur);

    // bit 1 bounces: 2 high samples, 1 low, then steady high
    hold_to(4);
    cur[1] = 1'b1;
    repeat (20) step(cur);
    cur[1] = 1'b0;
    repeat (10) step(cur);
    cur[1] = 1'b1;
    repeat (40) step(cur);

    // all buttons together, release then press then release
    cur = '0;
    repeat (60) step(cur);
    cur = '1;
    repeat (60) step(cur);
    cur = '0;
    repeat (60) step(cur);

    // reset in the middle of a scan with two differing samples counted on bit 0
    hold_to(4);
    cur = 4'b0001;
    hold_to(8);
    hold_to(8);
    hold_to(1);
    do_reset(3);
    repeat (60) step(cur);

    // one-cycle glitch on bit 3 between sample points
    hold_to(4);
    step(cur ^ 4'b1000);
    repeat (40) step(cur);

    // random traffic: bouncy first half, calmer second half, one random reset
    for (int k = 0; k < 1600; k++) begin
      if ($urandom_range(0, (k < 800) ? 11 : 59) == 0)
        cur[$urandom_range(0, NB - 1)] = ~cur[$urandom_range(0, NB - 1)];
      v = cur;
      if ($urandom_range(0, 15) == 0) v = v ^ 4'($urandom_range(1, 15));
      step(v);
      if (k == 700) do_reset(int'($urandom_range(1, 4)));
    end

    hold_to(5);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
